// File: rtl/ysyx_22040895_mdu_seq.sv
// RV64M multiply/divide sequencer: radix-2 shift-add multiplier and restoring divider, one bit per cycle.
// Latency: result valid ITER cycles after accept (64, or 32 for *W), next cycle for div-by-zero/overflow/illegal.
module ysyx_22040895_mdu_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [3:0]      mduop_i,
  input  logic            wordop_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            flush_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  state_t              state;
  logic [3:0]          op_q;
  logic                word_q;
  logic                neg_q;
  logic                rneg_q;
  logic [CW-1:0]       cnt;
  logic [2*XLEN-1:0]   prod;
  logic [2*XLEN-1:0]   mcand;
  logic [XLEN-1:0]     mplier;
  logic [XLEN-1:0]     rem;
  logic [XLEN-1:0]     quot;
  logic [XLEN-1:0]     dvsr;

  logic                is_mul, is_div, op_legal, s1_signed, s2_signed;
  logic                a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]     op1_x, op2_x, a_mag, b_mag, min_w, spec_res;

  always_comb begin
    is_mul    = (mduop_i >= 4'd1) && (mduop_i <= 4'd4);
    is_div    = (mduop_i >= 4'd5) && (mduop_i <= 4'd8);
    op_legal  = (is_mul || is_div) && !(wordop_i && (mduop_i inside {4'd2, 4'd3, 4'd4}));
    s1_signed = mduop_i inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd7};
    s2_signed = mduop_i inside {4'd1, 4'd2, 4'd5, 4'd7};
    op1_x     = op1_i;
    op2_x     = op2_i;
    if (wordop_i) begin
      op1_x = s1_signed ? sext32(op1_i[31:0]) : {{(XLEN-32){1'b0}}, op1_i[31:0]};
      op2_x = s2_signed ? sext32(op2_i[31:0]) : {{(XLEN-32){1'b0}}, op2_i[31:0]};
    end
    a_neg    = s1_signed & op1_x[XLEN-1];
    b_neg    = s2_signed & op2_x[XLEN-1];
    a_mag    = a_neg ? -op1_x : op1_x;
    b_mag    = b_neg ? -op2_x : op2_x;
    min_w    = wordop_i ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (op2_x == '0);
    // only div/rem are signed on both operands among the divide ops
    div_ovf  = is_div && s2_signed && (op1_x == min_w) && (op2_x == '1);
    if (mduop_i == 4'd5 || mduop_i == 4'd6) spec_res = div_zero ? '1 : op1_x;
    else                                     spec_res = div_zero ? op1_x : '0;
  end

  logic [2*XLEN-1:0] prod_nx, prod_fix;
  logic [XLEN:0]     rem_sh, diff;
  logic              ge;
  logic [XLEN-1:0]   rem_nx, quot_nx, q_fix, r_fix, mul_res, div_res, fin;

  always_comb begin
    prod_nx  = prod + (mplier[0] ? mcand : '0);
    rem_sh   = {rem, quot[XLEN-1]};
    diff     = rem_sh - {1'b0, dvsr};
    // rem_sh < 2*dvsr, so the top bit of the difference is a true sign bit
    ge       = !diff[XLEN];
    rem_nx   = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quot_nx  = {quot[XLEN-2:0], ge};
    prod_fix = neg_q ? -prod_nx : prod_nx;
    mul_res  = (op_q == 4'd1) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    q_fix    = neg_q ? -quot_nx : quot_nx;
    r_fix    = rneg_q ? -rem_nx : rem_nx;
    div_res  = (op_q == 4'd5 || op_q == 4'd6) ? q_fix : r_fix;
    fin      = (state == S_MUL) ? mul_res : div_res;
    if (word_q) fin = sext32(fin[31:0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      result_o     <= '0;
      op_q         <= '0;
      word_q       <= 1'b0;
      neg_q        <= 1'b0;
      rneg_q       <= 1'b0;
      cnt          <= '0;
      prod         <= '0;
      mcand        <= '0;
      mplier       <= '0;
      rem          <= '0;
      quot         <= '0;
      dvsr         <= '0;
    end else if (flush_i) begin
      state        <= S_IDLE;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      cnt          <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid_i) begin
          op_q        <= mduop_i;
          word_q      <= wordop_i;
          neg_q       <= a_neg ^ b_neg;
          rneg_q      <= a_neg;
          req_ready_o <= 1'b0;
          busy_o      <= 1'b1;
          if (!op_legal) begin
            state        <= S_DONE;
            resp_valid_o <= 1'b1;
            result_o     <= '0;
          end else if (is_div && (div_zero || div_ovf)) begin
            state        <= S_DONE;
            resp_valid_o <= 1'b1;
            result_o     <= wordop_i ? sext32(spec_res[31:0]) : spec_res;
          end else begin
            state  <= is_mul ? S_MUL : S_DIV;
            cnt    <= wordop_i ? CW'(32) : CW'(XLEN);
            prod   <= '0;
            mcand  <= {{XLEN{1'b0}}, a_mag};
            mplier <= b_mag;
            rem    <= '0;
            // word dividends are pre-aligned so their top bit is consumed first
            quot   <= wordop_i ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
            dvsr   <= b_mag;
          end
        end
        S_MUL: begin
          prod   <= prod_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state        <= S_DONE;
            resp_valid_o <= 1'b1;
            result_o     <= fin;
          end
        end
        S_DIV: begin
          rem  <= rem_nx;
          quot <= quot_nx;
          cnt  <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state        <= S_DONE;
            resp_valid_o <= 1'b1;
            result_o     <= fin;
          end
        end
        default: if (resp_ready_i) begin
          state        <= S_IDLE;
          resp_valid_o <= 1'b0;
          req_ready_o  <= 1'b1;
          busy_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule
